apb_lite_master: RTL



---
 rtl/apb_lite_pkg.sv | 18 +
 rtl/apb_lite_req_fifo.sv | 66 ++++++
 rtl/apb_lite_master.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/apb_lite_pkg.sv
// Shared definitions for the APB-lite initiator: FSM encoding and wait-timeout constants.
package apb_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    localparam logic [3:0]  WAIT_TIMEOUT  = 4'hF;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0000;

    // Width of one queued request: write flag, address, write data.
    function automatic int unsigned req_entry_w(input int unsigned addr_w);
        return 1 + addr_w + 32;
    endfunction

endpackage

// File: rtl/apb_lite_req_fifo.sv
// Small synchronous request FIFO with full/empty flags and an occupancy count.
module apb_lite_req_fifo #(
    parameter int unsigned WIDTH = 39,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       pclk,
    input  logic                       n_p_reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge pclk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/apb_lite_master.sv
// APB initiator: queued valid/ready requests become SETUP/ACCESS transfers with a response strobe.
// Define APB_LITE_MASTER_PREADY_EN to honour pready with a 15-stall timeout.
module apb_lite_master
    import apb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned REQ_DEPTH = 2
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready
);

    localparam int unsigned ENTRY_W = req_entry_w(ADDR_W);
    localparam int unsigned CNT_W   = $clog2(REQ_DEPTH + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_entry_t;

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    req_entry_t        push_entry;
    req_entry_t        head_entry;
    logic [ENTRY_W-1:0] fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              complete;
    logic              start_next;
    logic [31:0]       done_rdata;

`ifdef APB_LITE_MASTER_PREADY_EN
    logic [3:0]        wait_q, wait_d;
`else
    logic              pready_unused;
    assign pready_unused = pready;
`endif

    assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign head_entry = req_entry_t'(fifo_dout);
    assign fifo_push  = req_valid && req_ready;

    apb_lite_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .pclk      (pclk),
        .n_p_reset (n_p_reset),
        .push      (fifo_push),
        .din       (push_entry),
        .pop       (fifo_pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;
        complete    = 1'b0;
        start_next  = 1'b0;
        done_rdata  = '0;
`ifdef APB_LITE_MASTER_PREADY_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            ST_IDLE: start_next = !fifo_empty;
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
`ifdef APB_LITE_MASTER_PREADY_EN
                // A slave that never answers is cut off after WAIT_TIMEOUT stalls.
                if (pready) begin
                    complete   = 1'b1;
                    done_rdata = pwrite_q ? 32'h0 : prdata;
                end else if (wait_q == WAIT_TIMEOUT) begin
                    complete   = 1'b1;
                    done_rdata = TIMEOUT_RDATA;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
`else
                complete   = 1'b1;
                done_rdata = pwrite_q ? 32'h0 : prdata;
`endif
                if (complete) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = done_rdata;
                    start_next  = !fifo_empty;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
`ifdef APB_LITE_MASTER_PREADY_EN
                    wait_d      = '0;
`endif
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // Loading the head entry is shared by IDLE and back-to-back completion.
        if (start_next) begin
            fifo_pop  = 1'b1;
            pwrite_d  = head_entry.write;
            paddr_d   = head_entry.addr;
            pwdata_d  = head_entry.wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
        end
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_LITE_MASTER_PREADY_EN
            wait_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_LITE_MASTER_PREADY_EN
            wait_q      <= wait_d;
`endif
        end
    end

    assign req_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
